imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Descriptor, instruction-memory and status signals of the instruction-memory loader.
// master = the loader itself, slave = the surrounding environment.
interface imem_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  CUOp;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        imem_wen;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ack;
    logic        clear;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic        full;
    logic [15:0] word_count;

    modport master (
        input  in_valid, CUOp, rd, rs1, rs2, imm, imem_ack, clear,
        output in_ready, imem_wen, imem_addr, imem_wdata, err_pulse, err_count, full, word_count
    );

    modport slave (
        output in_valid, CUOp, rd, rs1, rs2, imm, imem_ack, clear,
        input  in_ready, imem_wen, imem_addr, imem_wdata, err_pulse, err_count, full, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Turns decoded instruction descriptors back into RV32I words and writes them
// sequentially into instruction memory starting at BASE_ADDR.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          nRst,
    imem_loader_if.master bus
);
    localparam logic [15:0] MAXW = 16'(MAX_WORDS);

    localparam logic [5:0] CU_LUI  = 6'd0,  CU_AUIPC = 6'd1,  CU_JAL  = 6'd2,  CU_JALR = 6'd3;
    localparam logic [5:0] CU_BEQ  = 6'd4,  CU_BNE   = 6'd5,  CU_BLT  = 6'd6,  CU_BGE  = 6'd7;
    localparam logic [5:0] CU_BLTU = 6'd8,  CU_BGEU  = 6'd9,  CU_LB   = 6'd10, CU_LH   = 6'd11;
    localparam logic [5:0] CU_LW   = 6'd12, CU_LBU   = 6'd13, CU_LHU  = 6'd14, CU_SB   = 6'd15;
    localparam logic [5:0] CU_SH   = 6'd16, CU_SW    = 6'd17, CU_ADDI = 6'd18, CU_SLTI = 6'd19;
    localparam logic [5:0] CU_SLTIU = 6'd20, CU_XORI = 6'd22, CU_ORI  = 6'd23, CU_ANDI = 6'd24;
    localparam logic [5:0] CU_SLLI = 6'd25, CU_SRLI  = 6'd26, CU_SRAI = 6'd27, CU_ADD  = 6'd28;
    localparam logic [5:0] CU_SUB  = 6'd29, CU_SLL   = 6'd30, CU_SLT  = 6'd31, CU_SLTU = 6'd32;
    localparam logic [5:0] CU_XOR  = 6'd33, CU_SRL   = 6'd34, CU_SRA  = 6'd35, CU_OR   = 6'd36;
    localparam logic [5:0] CU_AND  = 6'd37;

    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_op;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [31:0] r_imm;
    logic [31:0] r_wdata, r_addr;
    logic [15:0] r_wcnt;
    logic [7:0]  r_ecnt;
    logic        r_errp;
    logic        w_hs, w_full, w_legal;
    logic        w_i_ok, w_b_ok, w_j_ok;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_enc;

    function automatic logic [2:0] f3_of(input logic [5:0] op);
        case (op)
            CU_BNE, CU_LH, CU_SH, CU_SLLI, CU_SLL:             f3_of = 3'd1;
            CU_LW, CU_SW, CU_SLTI, CU_SLT:                     f3_of = 3'd2;
            CU_SLTIU, CU_SLTU:                                 f3_of = 3'd3;
            CU_BLT, CU_LBU, CU_XORI, CU_XOR:                   f3_of = 3'd4;
            CU_BGE, CU_LHU, CU_SRLI, CU_SRAI, CU_SRL, CU_SRA:  f3_of = 3'd5;
            CU_BLTU, CU_ORI, CU_OR:                            f3_of = 3'd6;
            CU_BGEU, CU_ANDI, CU_AND:                          f3_of = 3'd7;
            default:                                           f3_of = 3'd0;
        endcase
    endfunction

    assign w_full         = (r_wcnt == MAXW);
    assign bus.in_ready   = nRst && (r_state == IDLE) && !w_full;
    assign w_hs           = bus.in_valid && bus.in_ready;
    assign bus.imem_wen   = (r_state == WR);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.err_pulse  = r_errp;
    assign bus.err_count  = r_ecnt;
    assign bus.full       = w_full;
    assign bus.word_count = r_wcnt;

    // Immediate must be representable by sign-extension from the field's top bit
    assign w_i_ok = (&r_imm[31:11]) | ~(|r_imm[31:11]);
    assign w_b_ok = ((&r_imm[31:12]) | ~(|r_imm[31:12])) & ~r_imm[0];
    assign w_j_ok = ((&r_imm[31:20]) | ~(|r_imm[31:20])) & ~r_imm[0];
    assign w_f3   = f3_of(r_op);
    assign w_f7   = (r_op == CU_SRAI || r_op == CU_SUB || r_op == CU_SRA) ? 7'h20 : 7'h00;

    always_comb begin
        w_enc   = '0;
        w_legal = 1'b0;
        if (r_op == CU_LUI || r_op == CU_AUIPC) begin
            w_enc   = {r_imm[31:12], r_rd, (r_op == CU_LUI) ? 7'h37 : 7'h17};
            w_legal = (r_imm[11:0] == 12'd0);
        end else if (r_op == CU_JAL) begin
            w_enc   = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, 7'h6F};
            w_legal = w_j_ok;
        end else if (r_op == CU_JALR || (r_op >= CU_LB && r_op <= CU_LHU)) begin
            w_enc   = {r_imm[11:0], r_rs1, w_f3, r_rd, (r_op == CU_JALR) ? 7'h67 : 7'h03};
            w_legal = w_i_ok;
        end else if (r_op >= CU_BEQ && r_op <= CU_BGEU) begin
            w_enc   = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, w_f3, r_imm[4:1], r_imm[11], 7'h63};
            w_legal = w_b_ok;
        end else if (r_op >= CU_SB && r_op <= CU_SW) begin
            w_enc   = {r_imm[11:5], r_rs2, r_rs1, w_f3, r_imm[4:0], 7'h23};
            w_legal = w_i_ok;
        end else if (r_op >= CU_SLLI && r_op <= CU_SRAI) begin
            w_enc   = {w_f7, r_imm[4:0], r_rs1, w_f3, r_rd, 7'h13};
            w_legal = (r_imm[31:5] == 27'd0);
        end else if ((r_op >= CU_ADDI && r_op <= CU_SLTIU) || (r_op >= CU_XORI && r_op <= CU_ANDI)) begin
            w_enc   = {r_imm[11:0], r_rs1, w_f3, r_rd, 7'h13};
            w_legal = w_i_ok;
        end else if (r_op >= CU_ADD && r_op <= CU_AND) begin
            w_enc   = {w_f7, r_rs2, r_rs1, w_f3, r_rd, 7'h33};
            w_legal = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = ENC;
            ENC:     w_next = w_legal ? WR : IDLE;
            WR:      if (bus.imem_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Descriptor is frozen at the handshake so ENC never sees live inputs
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_op  <= bus.CUOp;
            r_rd  <= bus.rd;
            r_rs1 <= bus.rs1;
            r_rs2 <= bus.rs2;
            r_imm <= bus.imm;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wcnt  <= '0;
            r_ecnt  <= '0;
            r_errp  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_errp <= 1'b0;
            if (r_state == IDLE && bus.clear) begin
                r_wcnt <= '0;
                r_ecnt <= '0;
            end
            if (r_state == ENC) begin
                if (w_legal) begin
                    r_wdata <= w_enc;
                    r_addr  <= BASE_ADDR + {14'd0, r_wcnt, 2'b00};
                end else begin
                    r_errp <= 1'b1;
                    if (r_ecnt != 8'hFF) r_ecnt <= r_ecnt + 8'd1;
                end
            end
            if (r_state == WR && bus.imem_ack && !w_full) r_wcnt <= r_wcnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: encodings, legality rejects, full handling,
// clear and asynchronous reset behaviour.
module tb_imem_loader;
    logic clk;
    logic nRst;
    int   checks;
    int   failures;

    imem_loader_if bus ();

    imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(2)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input bit clr);
        int n;
        @(negedge clk);
        bus.CUOp = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
        bus.clear = clr; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.clear = 1'b0;
        bus.CUOp = 6'd63; bus.rd = 5'h1F; bus.rs1 = 5'h1F; bus.rs2 = 5'h1F; bus.imm = '1;
    endtask

    task automatic do_write(input string tag, input logic [31:0] ea, input logic [31:0] ed, input int dly);
        int n;
        chk({tag, "_enc_nowen"}, bus.imem_wen, 0);
        n = 0;
        while (!bus.imem_wen && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_wen"}, bus.imem_wen, 1);
        chk({tag, "_addr"}, bus.imem_addr, ea);
        chk({tag, "_data"}, bus.imem_wdata, ed);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({tag, "_hold_wen"}, bus.imem_wen, 1);
            chk({tag, "_hold_addr"}, bus.imem_addr, ea);
            chk({tag, "_hold_data"}, bus.imem_wdata, ed);
        end
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk({tag, "_done_wen"}, bus.imem_wen, 0);
    endtask

    task automatic expect_err(input string tag, input logic [7:0] ecnt);
        chk({tag, "_enc_nowen"}, bus.imem_wen, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, bus.err_pulse, 1);
        chk({tag, "_nowen"}, bus.imem_wen, 0);
        chk({tag, "_ecnt"}, bus.err_count, ecnt);
        @(negedge clk);
        chk({tag, "_pulse_end"}, bus.err_pulse, 0);
        chk({tag, "_nowen2"}, bus.imem_wen, 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        nRst = 1'b0;
        bus.in_valid = 1'b0; bus.CUOp = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.imm = '0; bus.imem_ack = 1'b0; bus.clear = 1'b0;

        #3;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_wen", bus.imem_wen, 0);
        chk("rst_pulse", bus.err_pulse, 0);
        chk("rst_wcnt", bus.word_count, 0);
        chk("rst_ecnt", bus.err_count, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_data", bus.imem_wdata, 0);
        @(negedge clk);
        nRst = 1'b1;

        // ADDI x1, x0, 5
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        do_write("addi", 32'h100, 32'h0050_0093, 0);
        chk("addi_wcnt", bus.word_count, 1);
        pulse_clear();
        chk("clr1_wcnt", bus.word_count, 0);

        // JAL x1, 8 then BEQ x1, x2, -4
        send(6'd2, 5'd1, 5'd3, 5'd4, 32'd8, 1'b0);
        do_write("jal", 32'h100, 32'h0080_00EF, 0);
        send(6'd4, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
        do_write("beq", 32'h104, 32'hFE20_8EE3, 0);
        chk("two_wcnt", bus.word_count, 2);
        chk("two_full", bus.full, 1);
        chk("two_ready", bus.in_ready, 0);
        pulse_clear();
        chk("clr2_full", bus.full, 0);
        chk("clr2_wcnt", bus.word_count, 0);

        // LUI legal, then LUI with low bits set
        send(6'd0, 5'd5, 5'd2, 5'd0, 32'h1234_5000, 1'b0);
        do_write("lui", 32'h100, 32'h1234_52B7, 0);
        send(6'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b0);
        expect_err("lui_bad", 8'd1);
        chk("lui_bad_wcnt", bus.word_count, 1);

        // Rejects: ADDI 2048, odd branch offset, reserved code 21, out-of-range code, wide shamt
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        expect_err("addi_2048", 8'd2);
        send(6'd4, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0);
        expect_err("beq_odd", 8'd3);
        send(6'd21, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        expect_err("code21", 8'd4);
        send(6'd38, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        expect_err("code38", 8'd5);
        send(6'd25, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0);
        expect_err("slli_32", 8'd6);
        chk("rej_wcnt", bus.word_count, 1);

        // SRAI x3, x4, 2 (rs2 field must not leak into the word)
        send(6'd27, 5'd3, 5'd4, 5'd9, 32'd2, 1'b0);
        do_write("srai", 32'h104, 32'h4022_5193, 0);
        pulse_clear();
        chk("clr3_ecnt", bus.err_count, 0);
        chk("clr3_wcnt", bus.word_count, 0);

        // Delayed acks up to full: SUB then SW, third descriptor must stall
        send(6'd29, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 1'b0);
        do_write("sub", 32'h100, 32'h4031_00B3, 3);
        send(6'd17, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFF8, 1'b0);
        do_write("sw", 32'h104, 32'hFE51_2C23, 3);
        chk("full_flag", bus.full, 1);
        @(negedge clk);
        bus.CUOp = 6'd18; bus.rd = 5'd1; bus.rs1 = 5'd0; bus.imm = 32'd1; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_ready", bus.in_ready, 0);
            chk("full_nowen", bus.imem_wen, 0);
        end
        bus.in_valid = 1'b0;
        chk("full_wcnt", bus.word_count, 2);
        pulse_clear();
        chk("clr4_full", bus.full, 0);

        // Reset during WR abandons the write
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        do_write("pre_rst", 32'h100, 32'h0050_0093, 0);
        send(6'd18, 5'd2, 5'd0, 5'd0, 32'd6, 1'b0);
        @(negedge clk);
        chk("wr_before_rst", bus.imem_wen, 1);
        chk("wr_before_rst_addr", bus.imem_addr, 32'h104);
        #1 nRst = 1'b0;
        #1;
        chk("rst_wr_wen", bus.imem_wen, 0);
        chk("rst_wr_wcnt", bus.word_count, 0);
        chk("rst_wr_ready", bus.in_ready, 0);
        chk("rst_wr_addr", bus.imem_addr, 0);
        @(negedge clk);
        nRst = 1'b1;

        // Clear together with a handshake
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        do_write("clr_hs1", 32'h100, 32'h0050_0093, 0);
        chk("clr_hs1_wcnt", bus.word_count, 1);
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        do_write("clr_hs2", 32'h100, 32'h0050_0093, 0);
        chk("clr_hs2_wcnt", bus.word_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
